// File: rtl/agc_timepulse_sequencer_if.sv
// Control/observation bundle between the AGC time-pulse sequencer and the gate network/monitor.
// Latency: none, wires only.
// Backpressure: none; run is a level and step_req is a one-cycle pulse.
interface agc_timepulse_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             step_req;
    logic             net_rst;
    logic             net_ce;
    logic [11:0]      tp;
    logic [3:0]       sub;
    logic             mct_end;
    logic             halted;
    logic [CNT_W-1:0] mct_count;

    // Sequencer side: takes run/step requests, drives network timing.
    modport master (
        input  run,
        input  step_req,
        output net_rst,
        output net_ce,
        output tp,
        output sub,
        output mct_end,
        output halted,
        output mct_count
    );

    // Monitor/network side.
    modport slave (
        output run,
        output step_req,
        input  net_rst,
        input  net_ce,
        input  tp,
        input  sub,
        input  mct_end,
        input  halted,
        input  mct_count
    );
endinterface

// File: rtl/agc_timepulse_sequencer.sv
// Divides clk into the twelve AGC time pulses T01..T12 (SUBSTEPS clocks each) and gates the NOR network.
// Latency: run seen in HALT on edge k gives net_ce in cycle k+1; one MCT = 12*SUBSTEPS executing cycles.
// Backpressure: none; run is sampled only at MCT boundaries, step_req outside HALT is dropped.
module agc_timepulse_sequencer #(
    parameter int SUBSTEPS = 4,
    parameter int RST_HOLD = 8,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    agc_timepulse_sequencer_if.master bus
);

    localparam logic [3:0]  SUB_MAX  = 4'(SUBSTEPS - 1);
    localparam logic [7:0]  HOLD_INI = 8'(RST_HOLD);
    localparam logic [11:0] TP_T01   = 12'h001;
    localparam logic [11:0] TP_T12   = 12'h800;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        HALT = 2'd1,
        RUN  = 2'd2,
        STEP = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [11:0]      tp;
    logic [3:0]       sub;
    logic [7:0]       hold;
    logic [CNT_W-1:0] mct_count;

    logic executing;
    logic tp_last_sub;
    logic mct_end;

    // Decodes shared by the FSM and the datapath.
    assign executing   = (state == RUN) || (state == STEP);
    assign tp_last_sub = (sub == SUB_MAX);
    assign mct_end     = executing && tp_last_sub && (tp == TP_T12);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: INIT always drains into HALT; executing states only leave at an MCT boundary.
    always_comb begin
        state_nxt = state;
        unique case (state)
            INIT: begin
                if (hold <= 8'd1) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                // run wins over a coincident step request.
                if (bus.run) begin
                    state_nxt = RUN;
                end else if (bus.step_req) begin
                    state_nxt = STEP;
                end
            end
            RUN: begin
                if (mct_end && !bus.run) begin
                    state_nxt = HALT;
                end
            end
            STEP: begin
                if (mct_end) begin
                    state_nxt = HALT;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    // Network reset hold counter: counts down while in INIT after rst falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= HOLD_INI;
        end else if ((state == INIT) && (hold != 8'd0)) begin
            hold <= hold - 8'd1;
        end
    end

    // Time-pulse position: advances only on executing cycles; T12 rotates back to T01.
    always_ff @(posedge clk) begin
        if (rst) begin
            tp  <= TP_T01;
            sub <= 4'd0;
        end else if (executing) begin
            if (tp_last_sub) begin
                sub <= 4'd0;
                tp  <= {tp[10:0], tp[11]};
            end else begin
                sub <= sub + 4'd1;
            end
        end
    end

    // Completed-MCT counter, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            mct_count <= '0;
        end else if (mct_end) begin
            mct_count <= mct_count + CNT_W'(1);
        end
    end

    assign bus.net_rst   = (state == INIT);
    assign bus.net_ce    = executing;
    assign bus.halted    = (state == HALT);
    assign bus.mct_end   = mct_end;
    assign bus.tp        = tp;
    assign bus.sub       = sub;
    assign bus.mct_count = mct_count;

endmodule
